// File: rtl/load_store_unit.sv
// Load/store unit: turns a decoded memory operation into a single
// valid/ready request on the data bus, waits for read data, formats the
// load result and stalls the core until the access has finished.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; a new op is latched and checked here
// REQ   | bus_valid high, request fields held until bus_ready
// WAIT  | read accepted, waiting for bus_rvalid
// DONE  | one cycle, stall low, load_data / error pulses valid
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        is_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // One extra bit so cnt_q + 1 can never wrap before the compare.
    localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT_CYCLES);

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [1:0]         size_q, size_d;
    logic               sgn_q, sgn_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        load_q, load_d;
    logic               mis_q, mis_d;
    logic               berr_q, berr_d;

    logic               op;
    logic               illegal;
    logic               cnt_expired;
    logic [1:0]         off;
    logic [31:0]        rdata_sh;
    logic [31:0]        load_fmt;

    assign op          = mem_read | mem_write;
    assign off         = addr_q[1:0];
    assign cnt_expired = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) >= TO_LIM;

    assign bus_addr     = {addr_q[31:2], 2'b00};
    assign bus_we       = we_q;
    assign load_data    = load_q;
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;

    // Classify the incoming op as illegal (bad size, misaligned, or read+write).
    always_comb begin
        illegal = 1'b0;
        case (mem_size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = addr[0];
            2'b10:   illegal = |addr[1:0];
            default: illegal = 1'b1;
        endcase
        if (mem_read && mem_write) illegal = 1'b1;
    end

    // Store lane steering from the latched request; strobes are zero for reads.
    always_comb begin
        bus_wstrb = 4'b0000;
        bus_wdata = wdata_q;
        case (size_q)
            2'b00: begin
                bus_wstrb = 4'b0001 << off;
                bus_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                bus_wstrb = 4'b0011 << off;
                bus_wdata = {2{wdata_q[15:0]}};
            end
            default: bus_wstrb = 4'b1111;
        endcase
        if (!we_q) bus_wstrb = 4'b0000;
    end

    // Load extraction and sign/zero extension of the addressed lane(s).
    always_comb begin
        rdata_sh = bus_rdata >> {off, 3'b000};
        load_fmt = bus_rdata;
        case (size_q)
            2'b00:   load_fmt = {{24{sgn_q & rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01:   load_fmt = {{16{sgn_q & rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_fmt = bus_rdata;
        endcase
    end

    // Next-state, latching, timeout and handshake outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        load_d    = load_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        stall     = 1'b0;
        bus_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall = op;
                if (op) begin
                    addr_d  = addr;
                    size_d  = mem_size;
                    sgn_d   = is_signed;
                    we_d    = mem_write;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    if (illegal) begin
                        state_d = S_DONE;
                        mis_d   = 1'b1;
                        load_d  = '0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall     = 1'b1;
                bus_valid = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                // An accepted request wins over a timeout in the same cycle.
                if (bus_ready) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end else if (cnt_expired) begin
                    state_d = S_DONE;
                    berr_d  = 1'b1;
                    load_d  = '0;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_rvalid) begin
                    state_d = S_DONE;
                    load_d  = load_fmt;
                end else if (cnt_expired) begin
                    state_d = S_DONE;
                    berr_d  = 1'b1;
                    load_d  = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            load_q  <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

endmodule
